multicycle_control_fsm: RTL

Sequencing controller for the multi-cycle RV32I core variant. It reuses the single-cycle control's decode semantics but issues them over several cycles per instruction through a Moore FSM.
- Drives the shared-memory, instruction-register, PC and ALU muxes of the multi-cycle datapath.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
- Stalls on a memory-ready handshake and traps on illegal opcodes.

---
 rtl/multicycle_control_fsm.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Sequencing controller for the multi-cycle RV32I core. A Moore FSM walks
//   each instruction through fetch, decode and execute/memory/writeback
//   states and drives the datapath muxes and enables from the current state.
//   Supported: lw, sw, R-type ALU, I-type ALU, beq, jal. Unknown opcodes trap
//   into ILLEGAL, which only reset leaves.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   Op         in   opcode from the instruction register
//   fun3       in   instr[14:12]
//   fun75      in   instr[30]
//   zero       in   ALU zero flag
//   mem_ready  in   shared memory completes the current access this cycle
//   PCWrite    out  PC register enable
//   AdrSrc     out  memory address select (0 PC, 1 Result)
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction register / OldPC enable
//   ResultSrc  out  result select (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUSrcA    out  ALU A select (00 PC, 01 OldPC, 10 RD1)
//   ALUSrcB    out  ALU B select (00 RD2, 01 ImmExt, 10 constant 4)
//   ImmSrc     out  immediate format (00 I, 01 S, 10 B, 11 J)
//   ALUControl out  ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   RegWrite   out  register file write enable
//   illegal    out  sticky illegal-instruction flag
//   state_dbg  out  current state encoding
module multicycle_control_fsm #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         Op,
  input  logic [2:0]         fun3,
  input  logic               fun75,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               RegWrite,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t      r_state;
  logic        r_illegal;
  logic        w_ready;
  logic [1:0]  w_aluop;
  logic        w_pcwrite;
  logic        w_memwrite;
  logic        w_irwrite;
  logic        w_regwrite;

  // With the handshake disabled every memory access completes in one cycle.
  assign w_ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  // ALUOp 00 add, 01 sub, 10 decode from funct fields.
  function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                            input logic [2:0] f3,
                                            input logic       op5,
                                            input logic       f75);
    logic [2:0] ctl;
    ctl = 3'b000;
    if (aluop == 2'b01) begin
      ctl = 3'b001;
    end else if (aluop == 2'b10) begin
      case (f3)
        3'b000:  ctl = (op5 & f75) ? 3'b001 : 3'b000;
        3'b010:  ctl = 3'b101;
        3'b110:  ctl = 3'b011;
        3'b111:  ctl = 3'b010;
        default: ctl = 3'b000;
      endcase
    end
    return ctl;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:    if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXECUTER;
            OP_I:         r_state <= S_EXECUTEI;
            OP_BEQ:       r_state <= S_BEQ;
            OP_JAL:       r_state <= S_JAL;
            default: begin
              r_state   <= S_ILLEGAL;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   r_state <= Op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (w_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (w_ready) r_state <= S_FETCH;
        S_EXECUTER: r_state <= S_ALUWB;
        S_EXECUTEI: r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BEQ:      r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
        S_ILLEGAL:  r_state <= S_ILLEGAL;
        // Unused encodings are treated as a corrupted sequence and trapped.
        default: begin
          r_state   <= S_ILLEGAL;
          r_illegal <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    w_aluop    = 2'b00;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irwrite = w_ready;
        w_pcwrite = w_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        w_aluop = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_aluop = 2'b10;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_BEQ: begin
        ALUSrcA   = 2'b10;
        w_aluop   = 2'b01;
        w_pcwrite = zero;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign ALUControl = alu_decode(w_aluop, fun3, Op[5], fun75);

  // FETCH decodes straight from mem_ready, so strobes are masked while reset
  // is held to keep the datapath from writing during reset.
  assign PCWrite   = w_pcwrite  & ~reset;
  assign MemWrite  = w_memwrite & ~reset;
  assign IRWrite   = w_irwrite  & ~reset;
  assign RegWrite  = w_regwrite & ~reset;
  assign illegal   = r_illegal;
  assign state_dbg = STATE_W'(r_state);

endmodule
